// File: rtl/lc3b_types.sv
// Shared lc3b types and encodings used by the writeback stage.
package lc3b_types;

  typedef logic [2:0] lc3b_nzp;

  localparam logic [3:0] op_br   = 4'b0000;
  localparam logic [3:0] op_jsr  = 4'b0100;
  localparam logic [3:0] op_jmp  = 4'b1100;
  localparam logic [3:0] op_trap = 4'b1111;

  localparam lc3b_nzp NZP_N = 3'b100;
  localparam lc3b_nzp NZP_Z = 3'b010;
  localparam lc3b_nzp NZP_P = 3'b001;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_BR   = 2'd2,
    WB_SEL_ZERO = 2'd3
  } wb_dsel_e;

  localparam logic [1:0] PCMUX_SEQ = 2'd0;
  localparam logic [1:0] PCMUX_BR  = 2'd1;
  localparam logic [1:0] PCMUX_REG = 2'd2;
  localparam logic [1:0] PCMUX_TRP = 2'd3;

  typedef enum logic {
    SQ_RUN    = 1'b0,
    SQ_SQUASH = 1'b1
  } wb_sq_state_e;

endpackage

// File: rtl/wb_cc_unit.sv
// Condition-code generation, CC register and branch compare for writeback.
module wb_cc_unit
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic [2:0]       nzp,
  input  logic [3:0]       opcode,
  output logic [2:0]       cc_out,
  output logic             br_taken
);

  lc3b_nzp w_gen;
  lc3b_nzp r_cc;

  always_comb begin
    w_gen = NZP_P;
    if (data == '0)
      w_gen = NZP_Z;
    else if (data[WIDTH-1])
      w_gen = NZP_N;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cc <= NZP_Z;
    else if (load)
      r_cc <= w_gen;
  end

  // Compare uses the registered CC: a same-packet CC load is seen next cycle.
  assign cc_out   = r_cc;
  assign br_taken = (opcode == op_br) & |(nzp & r_cc);

endmodule

// File: rtl/wb_stage_p.sv
// Parametrised lc3b writeback stage: data select, regfile write, CC,
// branch/jump redirect with post-redirect squash window, retired counter.
module wb_stage_p
  import lc3b_types::*;
#(
  parameter int WIDTH        = 16,
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       opcode,
  input  logic [2:0]       nzp,
  input  logic [REG_W-1:0] dr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] mem_in,
  input  logic [WIDTH-1:0] br_addr,
  input  logic [1:0]       data_sel,
  input  logic             load_cc,
  input  logic             load_regfile,
  input  logic [1:0]       pcmux_req,
  output logic [WIDTH-1:0] wbdata,
  output logic [REG_W-1:0] wbdr,
  output logic [WIDTH-1:0] wbpc,
  output logic             regfile_we,
  output logic [1:0]       pcmux_sel,
  output logic             pip_flush,
  output logic [2:0]       cc_out,
  output logic             squashing,
  output logic [CNT_W-1:0] retired
);

  localparam int SQ_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  wb_sq_state_e     r_state, w_state_nxt;
  logic [SQ_W-1:0]  r_sq_cnt, w_sq_cnt_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             w_live;
  logic             w_br_taken;
  logic             w_jump;
  logic             w_redirect;

  always_comb begin
    wbdata = '0;
    case (data_sel)
      WB_SEL_ALU: wbdata = alu_in;
      WB_SEL_MEM: wbdata = mem_in;
      WB_SEL_BR:  wbdata = br_addr;
      default:    wbdata = '0;
    endcase
  end

  assign squashing  = (r_state == SQ_SQUASH);
  assign w_live     = valid_in & ~squashing;
  assign wbdr       = dr;
  assign wbpc       = pc;
  assign regfile_we = w_live & load_regfile;

  wb_cc_unit #(.WIDTH(WIDTH)) u_cc (
    .clk      (clk),
    .reset    (reset),
    .data     (wbdata),
    .load     (w_live & load_cc),
    .nzp      (nzp),
    .opcode   (opcode),
    .cc_out   (cc_out),
    .br_taken (w_br_taken)
  );

  assign w_jump     = (opcode == op_jsr) | (opcode == op_jmp) | (opcode == op_trap);
  assign w_redirect = w_live & (w_br_taken | w_jump);
  assign pip_flush  = w_redirect;
  assign pcmux_sel  = w_redirect ? pcmux_req : PCMUX_SEQ;

  // Squash window: FLUSH_CYCLES cycles of squashing after each redirect.
  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    case (r_state)
      SQ_RUN: begin
        if (w_redirect && (FLUSH_CYCLES > 0)) begin
          w_state_nxt  = SQ_SQUASH;
          w_sq_cnt_nxt = SQ_W'(FLUSH_CYCLES - 1);
        end
      end
      SQ_SQUASH: begin
        if (r_sq_cnt == '0)
          w_state_nxt = SQ_RUN;
        else
          w_sq_cnt_nxt = r_sq_cnt - SQ_W'(1);
      end
      default: w_state_nxt = SQ_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SQ_RUN;
      r_sq_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_retired <= '0;
    else if (w_live)
      r_retired <= r_retired + CNT_W'(1);
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p: two instances (squash window 2 / 32-bit count, and
// no squash window / 4-bit count) driven together against a reference model.
module tb_wb_stage_p;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  opcode;
  logic [2:0]  nzp;
  logic [2:0]  dr;
  logic [15:0] pc, alu_in, mem_in, br_addr;
  logic [1:0]  data_sel;
  logic        load_cc, load_regfile;
  logic [1:0]  pcmux_req;

  logic [15:0] wbdata0, wbpc0, wbdata1, wbpc1;
  logic [2:0]  wbdr0, wbdr1, cc0, cc1;
  logic        we0, we1, flush0, flush1, sq0, sq1;
  logic [1:0]  pcm0, pcm1;
  logic [31:0] ret0;
  logic [3:0]  ret1;

  always #5 clk = ~clk;

  wb_stage_p #(.WIDTH(16), .REG_W(3), .FLUSH_CYCLES(2), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .nzp(nzp),
    .dr(dr), .pc(pc), .alu_in(alu_in), .mem_in(mem_in), .br_addr(br_addr),
    .data_sel(data_sel), .load_cc(load_cc), .load_regfile(load_regfile),
    .pcmux_req(pcmux_req), .wbdata(wbdata0), .wbdr(wbdr0), .wbpc(wbpc0),
    .regfile_we(we0), .pcmux_sel(pcm0), .pip_flush(flush0), .cc_out(cc0),
    .squashing(sq0), .retired(ret0));

  wb_stage_p #(.WIDTH(16), .REG_W(3), .FLUSH_CYCLES(0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .nzp(nzp),
    .dr(dr), .pc(pc), .alu_in(alu_in), .mem_in(mem_in), .br_addr(br_addr),
    .data_sel(data_sel), .load_cc(load_cc), .load_regfile(load_regfile),
    .pcmux_req(pcmux_req), .wbdata(wbdata1), .wbdr(wbdr1), .wbpc(wbpc1),
    .regfile_we(we1), .pcmux_sel(pcm1), .pip_flush(flush1), .cc_out(cc1),
    .squashing(sq1), .retired(ret1));

  int checks = 0;
  int errors = 0;

  // reference model state per instance
  int      m_flush[2] = '{2, 0};
  longint  m_mask[2]  = '{64'hFFFF_FFFF, 64'hF};
  logic [2:0] m_cc[2];
  int      m_sq[2];
  longint  m_ret[2];
  int      last_flush[2];
  int      last_pcm[2];
  int      sq_seen1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cc[k] = 3'b010; m_sq[k] = 0; m_ret[k] = 0;
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, then pass the edge.
  task automatic step();
    logic [15:0] d;
    logic [2:0]  gen;
    logic        live, taken, redir, jump;
    @(negedge clk);
    case (data_sel)
      2'd0: d = alu_in;
      2'd1: d = mem_in;
      2'd2: d = br_addr;
      default: d = 16'h0;
    endcase
    gen  = (d == 16'h0) ? 3'b010 : (d[15] ? 3'b100 : 3'b001);
    jump = (opcode == 4'b0100) || (opcode == 4'b1100) || (opcode == 4'b1111);
    for (int k = 0; k < 2; k++) begin
      live  = valid_in && (m_sq[k] == 0);
      taken = (opcode == 4'b0000) && ((nzp & m_cc[k]) != 3'b000);
      redir = live && (taken || jump);
      chk($sformatf("d%0d_wbdata", k), k ? wbdata1 : wbdata0, d);
      chk($sformatf("d%0d_wbdr", k),   k ? wbdr1 : wbdr0, dr);
      chk($sformatf("d%0d_wbpc", k),   k ? wbpc1 : wbpc0, pc);
      chk($sformatf("d%0d_we", k),     k ? we1 : we0, live && load_regfile);
      chk($sformatf("d%0d_flush", k),  k ? flush1 : flush0, redir);
      chk($sformatf("d%0d_pcmux", k),  k ? pcm1 : pcm0, redir ? pcmux_req : 2'b00);
      chk($sformatf("d%0d_cc", k),     k ? cc1 : cc0, m_cc[k]);
      chk($sformatf("d%0d_squash", k), k ? sq1 : sq0, m_sq[k] > 0);
      chk($sformatf("d%0d_retired", k), k ? 64'(ret1) : 64'(ret0), m_ret[k]);
      last_flush[k] = k ? int'(flush1) : int'(flush0);
      last_pcm[k]   = k ? int'(pcm1) : int'(pcm0);
      if (k == 1 && sq1) sq_seen1++;
      if (reset) begin
        m_cc[k] = 3'b010; m_sq[k] = 0; m_ret[k] = 0;
      end else begin
        if (live && load_cc) m_cc[k] = gen;
        if (m_sq[k] > 0) m_sq[k]--;
        else if (redir) m_sq[k] = m_flush[k];
        if (live) m_ret[k] = (m_ret[k] + 1) & m_mask[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic v, input logic [3:0] op, input logic [2:0] n,
                     input logic [1:0] sel, input logic [15:0] a, input logic [15:0] m,
                     input logic lcc, input logic lrf, input logic [1:0] req);
    valid_in = v; opcode = op; nzp = n; data_sel = sel; alu_in = a; mem_in = m;
    load_cc = lcc; load_regfile = lrf; pcmux_req = req;
    br_addr = 16'h3000; pc = 16'h0200; dr = 3'd3;
  endtask

  initial begin
    sq_seen1 = 0;
    reset = 1'b1;
    pkt(1'b0, 4'b0001, 3'b000, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    step();
    chk("reset_squash", sq0, 1'b0);
    chk("reset_cc", cc0, 3'b010);
    chk("reset_ret", ret0, 32'd0);
    reset = 1'b0;

    // ALU write with negative result
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h8000, 16'h0, 1'b1, 1'b1, 2'd0);
    step();
    chk("alu_neg_cc", cc0, 3'b100);
    chk("alu_neg_ret", ret0, 32'd1);

    // Branch taken on Z, then squash window swallows two ALU packets
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'd0);
    step();
    pkt(1'b1, 4'b0000, 3'b010, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd1);
    step();
    chk("br_taken_pcmux", last_pcm[0], 1);
    chk("br_taken_flush", last_flush[0], 1);
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h0005, 16'h0, 1'b1, 1'b1, 2'd0);
    step();
    step();
    chk("squash_cc_kept", cc0, 3'b010);
    chk("squash_ret_kept", ret0, 32'd3);
    chk("squash_done", sq0, 1'b0);

    // Branch not taken: CC=P, BR on N
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h0005, 16'h0, 1'b1, 1'b0, 2'd0);
    step();
    pkt(1'b1, 4'b0000, 3'b100, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd1);
    step();
    chk("br_nt_flush", last_flush[0], 0);
    chk("br_nt_pcmux", last_pcm[0], 0);
    chk("br_nt_nosquash", sq0, 1'b0);

    // Load sets Z, dependent branch next cycle is taken
    pkt(1'b1, 4'b0010, 3'b000, 2'd1, 16'h1234, 16'h0, 1'b1, 1'b1, 2'd0);
    step();
    pkt(1'b1, 4'b0000, 3'b010, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd1);
    step();
    chk("dep_br_taken", last_flush[0], 1);
    pkt(1'b0, 4'b0001, 3'b000, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd0);
    step();
    step();
    // same-packet variant compares against the old CC (P)
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h0007, 16'h0, 1'b1, 1'b0, 2'd0);
    step();
    pkt(1'b1, 4'b0000, 3'b010, 2'd1, 16'h0, 16'h0, 1'b1, 1'b0, 2'd1);
    step();
    chk("same_pkt_nt", last_flush[0], 0);
    chk("same_pkt_cc", cc0, 3'b010);

    // JMP on the no-window instance
    pkt(1'b1, 4'b1100, 3'b000, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd2);
    step();
    chk("jmp_pcmux", last_pcm[1], 2);
    chk("jmp_flush", last_flush[1], 1);
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h0001, 16'h0, 1'b0, 1'b1, 2'd0);
    step();
    chk("jmp_next_sq", sq1, 1'b0);

    // Reset in the middle of a squash window
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'd0);
    step();
    pkt(1'b1, 4'b0000, 3'b010, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd1);
    step();
    chk("pre_reset_sq", sq0, 1'b1);
    reset = 1'b1;
    pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'h8000, 16'h0, 1'b1, 1'b0, 2'd0);
    step();
    reset = 1'b0;
    chk("midsq_reset_sq", sq0, 1'b0);
    chk("midsq_reset_cc", cc0, 3'b010);
    chk("midsq_reset_ret", ret0, 32'd0);

    // 16 live non-redirect packets wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      pkt(1'b1, 4'b0001, 3'b000, 2'd0, 16'(i), 16'h0, 1'b0, 1'b1, 2'd0);
      step();
    end
    chk("wrap_ret1", ret1, 4'd0);
    chk("wrap_ret0", ret0, 32'd16);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      valid_in     = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: opcode = 4'b0000;
        1: opcode = 4'b0100;
        2: opcode = 4'b1100;
        3: opcode = 4'b1111;
        default: opcode = 4'($urandom_range(0, 15));
      endcase
      nzp          = 3'($urandom_range(0, 7));
      dr           = 3'($urandom_range(0, 7));
      pc           = 16'($urandom);
      alu_in       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      mem_in       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      br_addr      = 16'($urandom);
      data_sel     = 2'($urandom_range(0, 3));
      load_cc      = 1'($urandom_range(0, 1));
      load_regfile = 1'($urandom_range(0, 1));
      pcmux_req    = 2'($urandom_range(0, 3));
      step();
    end
    reset = 1'b0;
    chk("nosquash_inst1", 64'(sq_seen1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
